// File: rtl/main_adapter_outer_burst.sv
// Outer-side burst adapter: takes a transfer size on cmd, forwards that many
// words from the outer stream i to the hub stream o through a small FIFO and
// tags the final word. A size of 0 selects a zero-latency pass-through that
// runs until the hub reports the end of the stream on o_isLast_out.
module main_adapter_outer_burst #(
  parameter int W     = 64,
  parameter int LEN_W = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cmd,
  input  logic             cmd_isReady,
  output logic             cmd_canReceive,
  input  logic [W-1:0]     i,
  input  logic             i_isReady,
  output logic             i_canReceive,
  output logic [W-1:0]     o,
  output logic             o_isReady,
  input  logic             o_canReceive,
  output logic             o_isLast_in,
  input  logic             o_isLast_out,
  output logic             busy,
  output logic [LEN_W-1:0] wordCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CNT  = 2'd1,
    ST_AUTO = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] word_count_q, word_count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Each entry holds {last tag, data word}; read asynchronously so the head
  // is visible on o in the same cycle it becomes the oldest entry.
  logic [W:0]       mem_q [DEPTH];
  logic [W:0]       head;

  logic fifo_empty;
  logic fifo_full;
  logic cmd_fire;
  logic i_fire;
  logic push;
  logic pop;
  logic last_tag;
  logic wc_sat;

  assign fifo_empty = (count_q == '0);
  // Full blocks the input even if a pop happens in the same cycle.
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign head       = mem_q[rd_ptr_q];

  assign cmd_fire = cmd_isReady && cmd_canReceive;
  assign i_fire   = i_isReady && i_canReceive;
  assign push     = (state_q == ST_CNT) && i_fire;
  assign pop      = (state_q != ST_AUTO) && !fifo_empty && o_canReceive;
  assign last_tag = (remaining_q == LEN_W'(1));
  assign wc_sat   = &word_count_q;

  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign wordCount = word_count_q;

  // Handshake and output steering: pass-through in AUTO, FIFO head otherwise.
  always_comb begin
    cmd_canReceive = (state_q == ST_IDLE) && ((cmd != '0) || fifo_empty);
    i_canReceive   = 1'b0;
    o              = '0;
    o_isReady      = 1'b0;
    o_isLast_in    = 1'b0;
    case (state_q)
      ST_CNT:  i_canReceive = !fifo_full;
      ST_AUTO: begin
        i_canReceive = o_canReceive;
        o            = i;
        o_isReady    = i_isReady;
      end
      default: ;
    endcase
    // The FIFO is always empty in AUTO, so the head only drives o elsewhere.
    if ((state_q != ST_AUTO) && !fifo_empty) begin
      o           = head[W-1:0];
      o_isReady   = 1'b1;
      o_isLast_in = head[W];
    end
  end

  // Next-state logic for the mode FSM, burst countdown and word counter.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    word_count_d = word_count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          word_count_d = '0;
          if (cmd != '0) begin
            remaining_d = cmd;
            state_d     = ST_CNT;
          end else begin
            state_d = ST_AUTO;
          end
        end
      end
      ST_CNT: begin
        if (push) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (!wc_sat) word_count_d = word_count_q + LEN_W'(1);
          if (last_tag) state_d = ST_IDLE;
        end
      end
      ST_AUTO: begin
        if (i_fire && !wc_sat) word_count_d = word_count_q + LEN_W'(1);
        // The word transferring alongside o_isLast_out still completes.
        if (o_isLast_out) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Control state; reset drops FIFO contents and the countdown immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      word_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      word_count_q <= word_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {last_tag, i};
  end

endmodule

// File: tb/tb_main_adapter_outer_burst.sv
// Scoreboard bench for main_adapter_outer_burst: an input-side monitor runs a
// mode-level reference model and queues expected words, an output-side
// monitor pops and compares on every hub-side transfer.
module tb_main_adapter_outer_burst;

  localparam int W     = 32;
  localparam int LEN_W = 4;
  localparam int DEPTH = 4;
  localparam int WC_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [LEN_W-1:0] cmd = '0;
  logic             cmd_isReady = 1'b0;
  logic             cmd_canReceive;
  logic [W-1:0]     i = '0;
  logic             i_isReady = 1'b0;
  logic             i_canReceive;
  logic [W-1:0]     o;
  logic             o_isReady;
  logic             o_canReceive = 1'b0;
  logic             o_isLast_in;
  wire              o_isLast_out;
  logic             busy;
  logic [LEN_W-1:0] wordCount;

  // hub-side control
  int  o_mode = 0;       // 0: always ready, 1: random, 2: stalled until hold_until
  int  hold_until = 0;
  bit  noise = 1'b0;     // spurious o_isLast_out outside auto mode
  bit  in_auto = 1'b0;
  bit  auto_last = 1'b0;

  assign o_isLast_out = in_auto ? (auto_last & i_isReady & i_canReceive) : noise;

  main_adapter_outer_burst #(.W(W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_isReady(cmd_isReady), .cmd_canReceive(cmd_canReceive),
    .i(i), .i_isReady(i_isReady), .i_canReceive(i_canReceive),
    .o(o), .o_isReady(o_isReady), .o_canReceive(o_canReceive),
    .o_isLast_in(o_isLast_in), .o_isLast_out(o_isLast_out),
    .busy(busy), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           cyc;
    bit           auto_m;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  // reference model: 0 idle, 1 counted, 2 auto
  int mode_m = 0;
  int left_m = 0;
  int wc_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Input-side monitor: per-cycle handshake checks and model update.
  initial forever begin
    int  occ;
    bit  exp_cmd_can, exp_i_can, exp_o_rdy, i_xfer;
    @(negedge clk);
    if (!rst) begin
      exp_q.delete();
      mode_m = 0;
      left_m = 0;
      wc_m = 0;
      continue;
    end
    cyc++;
    occ = exp_q.size();
    exp_cmd_can = (mode_m == 0) && ((cmd != '0) || (occ == 0));
    exp_i_can   = (mode_m == 1) ? (occ < DEPTH) : (mode_m == 2) ? o_canReceive : 1'b0;
    exp_o_rdy   = (mode_m == 2) ? i_isReady : (occ != 0);
    check("cmd_canReceive", cmd_canReceive, exp_cmd_can);
    check("i_canReceive", i_canReceive, exp_i_can);
    check("o_isReady", o_isReady, exp_o_rdy);
    check("busy", busy, (mode_m != 0) || (occ != 0));
    check("wordCount", wordCount, wc_m);
    if (mode_m == 0 && occ == 0) begin
      check("idle_o", o, 0);
      check("idle_last", o_isLast_in, 0);
    end
    if (mode_m == 2) begin
      check("auto_o_eq_i", o, i);
      check("auto_last", o_isLast_in, 0);
    end
    i_xfer = i_isReady && exp_i_can;
    case (mode_m)
      0: if (cmd_isReady && exp_cmd_can) begin
        wc_m = 0;
        if (cmd != '0) begin
          mode_m = 1;
          left_m = int'(cmd);
        end else begin
          mode_m = 2;
        end
      end
      1: if (i_xfer) begin
        exp_q.push_back('{data: i, last: (left_m == 1), cyc: cyc, auto_m: 1'b0});
        left_m--;
        if (wc_m < WC_MAX) wc_m++;
        if (left_m == 0) mode_m = 0;
      end
      default: begin
        if (i_xfer) begin
          exp_q.push_back('{data: i, last: 1'b0, cyc: cyc, auto_m: 1'b1});
          if (wc_m < WC_MAX) wc_m++;
        end
        if (o_isLast_out) mode_m = 0;
      end
    endcase
  end

  // Output-side monitor: compare every hub-side transfer with the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst) continue;
    if (o_isReady && o_canReceive) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_o: got word %0h, expected no transfer (cycle %0d)", o, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("xfer cycle %0d: o=%0h last=%0b expected %0h last=%0b", cyc, o, o_isLast_in, e.data, e.last);
        check("o_data", o, e.data);
        check("o_last", o_isLast_in, e.last);
        if (e.auto_m) check("auto_latency", cyc, e.cyc);
        else          check("cnt_latency", (cyc > e.cyc), 1);
      end
    end
  end

  // Hub-side ready driver.
  initial forever begin
    @(posedge clk);
    #1;
    case (o_mode)
      0:       o_canReceive = 1'b1;
      1:       o_canReceive = 1'($urandom_range(0, 1));
      default: o_canReceive = (cyc >= hold_until);
    endcase
    noise = (o_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  task automatic send_cmd(input int n);
    bit acc = 1'b0;
    cmd = LEN_W'(n);
    cmd_isReady = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      acc = cmd_canReceive;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check("cmd_accept_timeout", acc, 1);
    cmd_isReady = 1'b0;
    cmd = LEN_W'($urandom);
  endtask

  task automatic send_words(input int n, input bit gaps, input bit mark_last);
    bit acc;
    for (int w = 0; w < n; w++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_isReady = 1'b0;
        @(posedge clk);
        #1;
      end
      i = $urandom;
      i_isReady = 1'b1;
      auto_last = mark_last && (w == n - 1);
      acc = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        acc = i_canReceive;
        @(posedge clk);
        #1;
        if (acc) break;
      end
      check("word_accept_timeout", acc, 1);
      i_isReady = 1'b0;
      auto_last = 1'b0;
      i = $urandom;
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      idle = !busy;
      @(posedge clk);
      #1;
      if (idle) break;
    end
    check("idle_timeout", idle, 1);
  endtask

  initial begin
    // reset state
    #3;
    check("rst_cmd_canReceive", cmd_canReceive, 1);
    check("rst_i_canReceive", i_canReceive, 0);
    check("rst_o_isReady", o_isReady, 0);
    check("rst_o_isLast_in", o_isLast_in, 0);
    check("rst_busy", busy, 0);
    check("rst_o", o, 0);
    check("rst_wordCount", wordCount, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // counted burst of 3, hub always ready
    o_mode = 0;
    send_cmd(3);
    send_words(3, 1'b0, 1'b0);
    wait_idle();
    check("t1_wordCount", wordCount, 3);

    // backpressure: 6 words into a 4-deep FIFO with the hub stalled
    o_mode = 2;
    hold_until = cyc + 14;
    send_cmd(6);
    send_words(6, 1'b0, 1'b0);
    wait_idle();
    check("t2_wordCount", wordCount, 6);

    // overlapped bursts 2 then 1
    o_mode = 2;
    hold_until = cyc + 6;
    send_cmd(2);
    send_words(2, 1'b0, 1'b0);
    send_cmd(1);
    send_words(1, 1'b0, 1'b0);
    wait_idle();

    // auto command held off by a draining FIFO, then 5 auto words
    o_mode = 2;
    hold_until = cyc + 8;
    send_cmd(2);
    send_words(2, 1'b0, 1'b0);
    send_cmd(0);
    o_mode = 0;
    in_auto = 1'b1;
    send_words(5, 1'b0, 1'b1);
    in_auto = 1'b0;
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_wordCount", wordCount, 5);
    @(posedge clk);
    #1;

    // wordCount saturation in auto mode
    send_cmd(0);
    in_auto = 1'b1;
    send_words(WC_MAX + 5, 1'b0, 1'b1);
    in_auto = 1'b0;
    check("t5_wordCount_sat", wordCount, WC_MAX);

    // asynchronous reset in the middle of a burst of 4
    o_mode = 2;
    hold_until = cyc + 1000;
    send_cmd(4);
    send_words(2, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_o_isReady", o_isReady, 0);
    check("t6_cmd_canReceive", cmd_canReceive, 1);
    check("t6_wordCount", wordCount, 0);
    check("t6_o", o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    o_mode = 0;
    send_cmd(1);
    send_words(1, 1'b0, 1'b0);
    wait_idle();
    check("t6_after_wordCount", wordCount, 1);

    // randomized mix of counted and auto transfers with a random hub
    o_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 7);
      if (n == 0) begin
        send_cmd(0);
        in_auto = 1'b1;
        send_words($urandom_range(1, 6), 1'b1, 1'b1);
        in_auto = 1'b0;
      end else begin
        send_cmd(n);
        send_words(n, 1'b1, 1'b0);
      end
    end
    o_mode = 0;
    wait_idle();
    @(negedge clk);
    check("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_adapter_outer_burst.md
MAIN_ADAPTER_OUTER_BURST -- requirements
Module: main_adapter_outer_burst

Interface
REQ-001 Parameter W, default 64: data word width in bits.
REQ-002 Parameter LEN_W, default 15: width of the size field and of the word counter.
REQ-003 Parameter DEPTH, default 4: data FIFO entries; power of two, at least 2.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port cmd, input, LEN_W: transfer size in words; 0 selects automatic mode.
REQ-007 Ports cmd_isReady (input, 1) and cmd_canReceive (output, 1): command handshake; a command is accepted when both are high.
REQ-008 Ports i (input, W), i_isReady (input, 1) and i_canReceive (output, 1): outer-side source stream.
REQ-009 Ports o (output, W), o_isReady (output, 1) and o_canReceive (input, 1): hub-side sink stream.
REQ-010 Port o_isLast_in, output, 1: marks the word currently on o as the last word of a counted burst.
REQ-011 Port o_isLast_out, input, 1: the hub reports that the last word of the stream has transferred; this ends automatic mode.
REQ-012 Port busy, output, 1: high when the state is not IDLE or the FIFO is non-empty.
REQ-013 Port wordCount, output, LEN_W: number of words accepted on i since the last accepted command.

Function
REQ-014 A transfer on i or o occurs in any cycle where isReady and canReceive are both high.
REQ-015 The FSM has three states:
- IDLE: no command active.
- CNT: counted burst, input side active.
- AUTO: automatic pass-through.
REQ-016 cmd_canReceive is asserted only in these cases:
- IDLE with cmd != 0: always.
- IDLE with cmd == 0: only when the FIFO is empty.
- Never in CNT or AUTO.
REQ-017 Accepting cmd = N with N != 0 loads remaining = N, clears wordCount and enters CNT on the next cycle.
REQ-018 In CNT, i_canReceive is asserted while the FIFO is not full.
REQ-019 In CNT, each accepted i word is pushed into the FIFO together with a last tag, and remaining is decremented.
REQ-020 The last tag is 1 exactly when remaining == 1 at the push.
REQ-021 The push with remaining == 1 returns the FSM to IDLE on the next cycle; the FIFO keeps draining in IDLE.
REQ-022 A new counted command may be accepted in IDLE while the FIFO still drains; word order and last tags are preserved across bursts.
REQ-023 While the FIFO is non-empty:
- o = head data.
- o_isReady = 1.
- o_isLast_in = head last tag.
- The head pops on an o transfer.
REQ-024 Counted-mode latency: a word accepted on i at cycle t appears on o no earlier than cycle t+1.
REQ-025 Counted-mode throughput: one word per cycle when o_canReceive stays high.
REQ-026 Accepting cmd = 0 clears wordCount and enters AUTO; this is only possible with the FIFO empty.
REQ-027 In AUTO the block is a combinational pass-through with zero latency:
- o = i.
- o_isReady = i_isReady.
- i_canReceive = o_canReceive.
- o_isLast_in = 0.
REQ-028 In AUTO, o_isLast_out high returns the FSM to IDLE on the next cycle; the transfer in that same cycle completes normally.
REQ-029 In IDLE with the FIFO empty: i_canReceive = 0, o_isReady = 0, o_isLast_in = 0, and o = 0.
REQ-030 A simultaneous FIFO push and pop on a full FIFO is not permitted: i_canReceive is gated by full, not by full-and-popping.
REQ-031 A simultaneous push and pop on a non-empty FIFO keeps the occupancy unchanged.
REQ-032 wordCount increments on every i transfer in CNT and AUTO, saturates at 2^LEN_W-1, and holds its value in IDLE.
REQ-033 o_isLast_out received outside AUTO is ignored.
REQ-034 cmd_isReady received while cmd_canReceive is low is ignored; the command must be held by the sender.

Reset
REQ-035 While rst is low, the block is held in reset: FSM = IDLE, FIFO empty, remaining = 0, wordCount = 0.
REQ-036 Output values during and directly after reset:
- cmd_canReceive = 1.
- i_canReceive, o_isReady, o_isLast_in, busy = 0.
- o = 0, wordCount = 0.
REQ-037 A reset asserted mid-burst discards all FIFO contents and the remaining count immediately, without waiting for a clock edge.
REQ-038 Operation resumes on the first rising clk edge after rst is deasserted.

Verification
REQ-039 Counted burst: cmd = 3, o_canReceive = 1, i supplies A, B, C back-to-back -> o shows A, B, C on consecutive cycles starting one cycle after A is accepted; o_isLast_in is high only with C; wordCount = 3; FSM returns to IDLE.
REQ-040 Backpressure: cmd = 6 with DEPTH = 4 and o_canReceive = 0 -> i_canReceive drops after 4 words; releasing o_canReceive delivers all 6 words in order with the last tag only on word 6.
REQ-041 Overlapped bursts: cmd = 2, then cmd = 1 accepted while the FIFO still holds words -> o shows X1, X2 (last), Y1 (last) with no gap when o_canReceive = 1.
REQ-042 Auto mode: with the FIFO empty, cmd = 0, then 5 words, with o_isLast_out pulsed together with word 5 -> o equals i in the same cycle for every word; the FSM is IDLE on the next cycle; wordCount = 5.
REQ-043 Auto command blocked: cmd = 0 presented while 2 words remain in the FIFO -> cmd_canReceive stays 0 until the FIFO empties, then the command is accepted.
REQ-044 Reset mid-burst: rst driven low after 2 of 4 words of cmd = 4 -> busy = 0, o_isReady = 0 and cmd_canReceive = 1 at once; a subsequent cmd = 1 completes normally.
